// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b one bit per clock, LSB first,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             d_bit, br_next;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  assign d_bit   = opa_q[0] ^ opb_q[0] ^ br_q;
  assign br_next = (~opa_q[0] & opb_q[0]) | (~(opa_q[0] ^ opb_q[0]) & br_q);

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_d;
          borrow_d = br_next;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases, backpressure, reset abort,
// random stream against an arithmetic model, and a WIDTH=1 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, borrow;
  logic [7:0] a = '0, b = '0, diff;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic       in_ready1, out_valid1, borrow1;
  logic [0:0] a1 = '0, b1 = '0, diff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .borrow(borrow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: plain modular arithmetic and unsigned compare.
  function automatic logic [8:0] model(input int unsigned av, input int unsigned bv, input int w);
    int unsigned m;
    m = (1 << w) - 1;
    return {1'(av < bv), 8'((av - bv) & m)};
  endfunction

  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output logic [7:0] dv, output logic bo, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    dv = diff; bo = borrow;
  endtask

  task automatic run1(input logic av, input logic bv,
                      output logic dv, output logic bo, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready1 && guard < 100) begin @(negedge clk); guard++; end
    a1 = av; b1 = bv; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 100) begin @(negedge clk); lat++; end
    dv = diff1[0]; bo = borrow1;
  endtask

  logic [7:0] dv;
  logic       bo, dv1;
  int         lat;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  initial begin
    int sent, got, cyc;
    logic pending;

    // Reset
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic op and latency
    out_ready = 1'b1;
    run8(8'd200, 8'd55, dv, bo, lat);
    check("t1_out_valid", out_valid, 1);
    check("t1_latency", lat, 8);
    check("t1_diff", dv, 145);
    check("t1_borrow", bo, 0);
    @(negedge clk);
    check("t1_in_ready_back", in_ready, 1);
    check("t1_out_valid_drop", out_valid, 0);

    // Directed borrow/zero cases
    run8(8'd5, 8'd9, dv, bo, lat);
    check("t2a_diff", dv, 252);  check("t2a_borrow", bo, 1);
    run8(8'd0, 8'd255, dv, bo, lat);
    check("t2b_diff", dv, 1);    check("t2b_borrow", bo, 1);
    run8(8'hA5, 8'hA5, dv, bo, lat);
    check("t2c_diff", dv, 0);    check("t2c_borrow", bo, 0);

    // Backpressure with a pending new operation
    @(negedge clk);
    out_ready = 1'b0;
    run8(8'd100, 8'd1, dv, bo, lat);
    check("t3_out_valid", out_valid, 1);
    a = 8'd7; b = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_diff", diff, 99);
      check("t3_hold_borrow", borrow, 0);
      check("t3_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_idle_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("t3_second_valid", out_valid, 1);
    check("t3_second_diff", diff, 4);
    check("t3_second_borrow", borrow, 0);
    @(negedge clk);

    // Reset in the middle of RUN
    a = 8'd50; b = 8'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_diff", diff, 0);
    check("t4_borrow", borrow, 0);
    @(negedge clk);
    rst = 1'b0;
    run8(8'd30, 8'd10, dv, bo, lat);
    check("t4_after_latency", lat, 8);
    check("t4_after_diff", dv, 20);
    check("t4_after_borrow", bo, 0);
    @(negedge clk);

    // Random stream with random backpressure
    sent = 0; got = 0; cyc = 0; pending = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    while (got < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pending) begin
        a = 8'($urandom); b = 8'($urandom);
        pending = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 200);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t5_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("t5_diff", diff, e[7:0]);
          check("t5_borrow", borrow, e[8]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, 8));
        sent++;
        pending = 1'b1;
      end
    end
    check("t5_results_received", got, 200);
    check("t5_queue_empty", exp_q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_extra_result", out_valid, 0);

    // WIDTH=1 instance, all four combinations
    for (int i = 0; i < 4; i++) begin
      run1(1'(i), 1'(i >> 1), dv1, bo, lat);
      e = model(i & 1, (i >> 1) & 1, 1);
      check("t6_latency", lat, 1);
      check("t6_diff", dv1, e[0]);
      check("t6_borrow", bo, e[8]);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
